game_sprite_cmd_arbiter: RTL and testbench

Shares the write ports of one sprite position/velocity controller among `N_REQ` command sources, such as the CPU, collision logic, player input and spawn logic. Each source presents position and/or velocity commands on a valid/ready handshake. The arbiter selects one source per grant using round-robin priority and issues the command as single-cycle write strobes. It gates the controller's `sprite_enable_update` so no autonomous movement step happens while a command is in flight or during a short settle window after it.

---
 rtl/game_sprite_cmd_pkg.sv | 25 ++
 rtl/game_rr_arbiter.sv | 32 +++
 rtl/game_sprite_cmd_arbiter.sv | 114 +++++++++++
 tb/tb_game_sprite_cmd_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_sprite_cmd_pkg.sv
// Shared types for the sprite command arbiter: command kinds and arbiter FSM states.
package game_sprite_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_XY   = 2'b01,
    CMD_DXY  = 2'b10,
    CMD_BOTH = 2'b11
  } cmd_kind_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_HOLD  = 2'd2
  } arb_state_t;

  function automatic logic kind_has_xy(input cmd_kind_t kind);
    return (kind == CMD_XY) || (kind == CMD_BOTH);
  endfunction

  function automatic logic kind_has_dxy(input cmd_kind_t kind);
    return (kind == CMD_DXY) || (kind == CMD_BOTH);
  endfunction

endpackage

// File: rtl/game_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last_grant+1.
module game_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         gnt_onehot,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     any
);

  localparam int GW = $clog2(N_REQ);

  logic [GW-1:0] cand;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % N_REQ);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sprite_cmd_arbiter.sv
// Round-robin arbiter that funnels N_REQ sprite commands into single-cycle controller writes,
// holding off autonomous movement while a command is in flight and for HOLD_CYCLES after it.
module game_sprite_cmd_arbiter
  import game_sprite_cmd_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int w_x         = 10,
  parameter int w_y         = 9,
  parameter int DX_WIDTH    = 2,
  parameter int DY_WIDTH    = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               run_enable,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][1:0]              req_kind,
  input  logic [N_REQ-1:0][w_x-1:0]          req_x,
  input  logic [N_REQ-1:0][w_y-1:0]          req_y,
  input  logic [N_REQ-1:0][DX_WIDTH-1:0]     req_dx,
  input  logic [N_REQ-1:0][DY_WIDTH-1:0]     req_dy,
  output logic                               sprite_write_xy,
  output logic                               sprite_write_dxy,
  output logic [w_x-1:0]                     sprite_write_x,
  output logic [w_y-1:0]                     sprite_write_y,
  output logic signed [DX_WIDTH-1:0]         sprite_write_dx,
  output logic signed [DY_WIDTH-1:0]         sprite_write_dy,
  output logic                               sprite_enable_update,
  output logic [$clog2(N_REQ)-1:0]           grant_id,
  output logic                               busy
);

  localparam int GW   = $clog2(N_REQ);
  localparam int HC_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE  = ARB_IDLE;
  localparam logic [1:0] S_ISSUE = ARB_ISSUE;
  localparam logic [1:0] S_HOLD  = ARB_HOLD;

  logic [1:0]       state;
  logic [GW-1:0]    last_grant;
  cmd_kind_t        kind_q;
  logic [HC_W-1:0]  hold_cnt;
  logic             in_idle;
  logic [N_REQ-1:0] gnt_onehot;
  logic [GW-1:0]    gnt_idx;
  logic             any_req;

  game_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  assign in_idle = (state == S_IDLE);

  // Ready depends only on valid and state, never on kind or data.
  assign req_ready = in_idle ? gnt_onehot : '0;

  // Strobes decode from registered state, so an async reset kills them immediately.
  assign sprite_write_xy      = (state == S_ISSUE) && kind_has_xy(kind_q);
  assign sprite_write_dxy     = (state == S_ISSUE) && kind_has_dxy(kind_q);
  assign sprite_enable_update = run_enable && in_idle;
  assign busy                 = !in_idle;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      last_grant      <= GW'(N_REQ - 1);
      grant_id        <= '0;
      kind_q          <= CMD_NOP;
      hold_cnt        <= '0;
      sprite_write_x  <= '0;
      sprite_write_y  <= '0;
      sprite_write_dx <= '0;
      sprite_write_dy <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            last_grant <= gnt_idx;
            grant_id   <= gnt_idx;
            if (req_kind[gnt_idx] != CMD_NOP) begin
              kind_q          <= cmd_kind_t'(req_kind[gnt_idx]);
              sprite_write_x  <= req_x[gnt_idx];
              sprite_write_y  <= req_y[gnt_idx];
              sprite_write_dx <= req_dx[gnt_idx];
              sprite_write_dy <= req_dy[gnt_idx];
              state           <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (HOLD_CYCLES > 0) begin
            hold_cnt <= HC_W'(HOLD_CYCLES);
            state    <= S_HOLD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HC_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sprite_cmd_arbiter.sv
// Directed bench: reset, round-robin table, hold timing, BOTH command, HOLD_CYCLES=0 NOP path, reset mid-issue.
module tb_game_sprite_cmd_arbiter;
  import game_sprite_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic run_enable;
  logic [3:0]       req_valid;
  logic [3:0][1:0]  req_kind;
  logic [3:0][9:0]  req_x;
  logic [3:0][8:0]  req_y;
  logic [3:0][1:0]  req_dx;
  logic [3:0][1:0]  req_dy;

  logic [3:0] ready;
  logic       wxy, wdxy, en, busy;
  logic [9:0] wx;
  logic [8:0] wy;
  logic [1:0] wdx, wdy, gid;

  logic [3:0] ready_z;
  logic       wxy_z, wdxy_z, en_z, busy_z;
  logic [9:0] wx_z;
  logic [8:0] wy_z;
  logic [1:0] wdx_z, wdy_z, gid_z;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  game_sprite_cmd_arbiter #(.HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .run_enable(run_enable),
    .req_valid(req_valid), .req_ready(ready), .req_kind(req_kind),
    .req_x(req_x), .req_y(req_y), .req_dx(req_dx), .req_dy(req_dy),
    .sprite_write_xy(wxy), .sprite_write_dxy(wdxy),
    .sprite_write_x(wx), .sprite_write_y(wy),
    .sprite_write_dx(wdx), .sprite_write_dy(wdy),
    .sprite_enable_update(en), .grant_id(gid), .busy(busy)
  );

  game_sprite_cmd_arbiter #(.HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .run_enable(run_enable),
    .req_valid(req_valid), .req_ready(ready_z), .req_kind(req_kind),
    .req_x(req_x), .req_y(req_y), .req_dx(req_dx), .req_dy(req_dy),
    .sprite_write_xy(wxy_z), .sprite_write_dxy(wdxy_z),
    .sprite_write_x(wx_z), .sprite_write_y(wy_z),
    .sprite_write_dx(wdx_z), .sprite_write_dy(wdy_z),
    .sprite_enable_update(en_z), .grant_id(gid_z), .busy(busy_z)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic [1:0] gid;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ids [$];
    int cycs [$];
    logic [1:0] g;

    vecs[0]  = '{4'b0100, 4'b0100, 2'd2};
    vecs[1]  = '{4'b1111, 4'b1000, 2'd3};
    vecs[2]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[3]  = '{4'b1111, 4'b0010, 2'd1};
    vecs[4]  = '{4'b1111, 4'b0100, 2'd2};
    vecs[5]  = '{4'b1111, 4'b1000, 2'd3};
    vecs[6]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[7]  = '{4'b1010, 4'b0010, 2'd1};
    vecs[8]  = '{4'b1010, 4'b1000, 2'd3};
    vecs[9]  = '{4'b1010, 4'b0010, 2'd1};
    vecs[10] = '{4'b0001, 4'b0001, 2'd0};
    vecs[11] = '{4'b0001, 4'b0001, 2'd0};
    vecs[12] = '{4'b1001, 4'b1000, 2'd3};

    run_enable = 1'b1;
    req_kind   = '0;
    req_x      = '0;
    req_y      = '0;
    req_dx     = '0;
    req_dy     = '0;

    // Reset state, both while held and just after release.
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("rst_xy", wxy, 0);
    check("rst_dxy", wdxy, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 4'b0000);
    check("rst_en", en, 1);
    check("rst_gid", gid, 0);
    check("rst_x", wx, 0);
    check("rst_dx", wdx, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_en", en, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", ready, 4'b0000);

    // Requester 2 XY, hold timing, a late NOP request from requester 1.
    req_kind[2] = CMD_XY;
    req_x[2]    = 10'd100;
    req_y[2]    = 9'd50;
    req_valid   = 4'b0100;
    #1 check("xy_ready", ready, 4'b0100);
    @(posedge clk);
    #1;
    req_kind[1] = CMD_NOP;
    req_valid   = 4'b0010;
    @(negedge clk);
    check("xy_t1_xy", wxy, 1);
    check("xy_t1_dxy", wdxy, 0);
    check("xy_t1_x", wx, 100);
    check("xy_t1_y", wy, 50);
    check("xy_t1_en", en, 0);
    check("xy_t1_busy", busy, 1);
    check("xy_t1_gid", gid, 2);
    check("xy_t1_ready", ready, 4'b0000);
    @(negedge clk);
    check("xy_t2_xy", wxy, 0);
    check("xy_t2_en", en, 0);
    check("xy_t2_ready", ready, 4'b0000);
    @(negedge clk);
    check("xy_t3_en", en, 0);
    check("xy_t3_ready", ready, 4'b0000);
    @(negedge clk);
    check("xy_t4_en", en, 1);
    check("xy_t4_busy", busy, 0);
    check("xy_t4_ready", ready, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("nop_busy", busy, 0);
    check("nop_xy", wxy, 0);
    check("nop_dxy", wdxy, 0);
    check("nop_gid", gid, 1);

    // All four requesters continuously valid with DXY: order and spacing.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_kind[i] = CMD_DXY;
      req_x[i]    = 10'(10 * (i + 1));
      req_dx[i]   = 2'(i);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wdxy) begin
        ids.push_back(int'(gid));
        cycs.push_back(c);
      end
    end
    req_valid = '0;
    check("rr_count_ge5", ids.size() >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      if (k < ids.size()) check($sformatf("rr_id%0d", k), ids[k], k % 4);
      if (k > 0 && k < cycs.size()) check($sformatf("rr_gap%0d", k), cycs[k] - cycs[k-1], 4);
    end

    // Table-driven round-robin vectors from a fresh reset.
    do_reset();
    for (int v = 0; v < 13; v++) begin
      req_valid = vecs[v].valid;
      #1 check($sformatf("tbl%0d_ready", v), ready, vecs[v].ready);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      g = vecs[v].gid;
      check($sformatf("tbl%0d_dxy", v), wdxy, 1);
      check($sformatf("tbl%0d_gid", v), gid, g);
      check($sformatf("tbl%0d_x", v), wx, 10 * (int'(g) + 1));
      check($sformatf("tbl%0d_dx", v), wdx, g);
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_idle", v), busy, 0);
    end

    // BOTH with dx=-1, dy=+1.
    do_reset();
    req_kind[1] = CMD_BOTH;
    req_dx[1]   = 2'b11;
    req_dy[1]   = 2'b01;
    req_valid   = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("both_xy", wxy, 1);
    check("both_dxy", wdxy, 1);
    check("both_dx", wdx, 2'b11);
    check("both_dy", wdy, 2'b01);
    check("both_gid", gid, 1);
    repeat (3) @(negedge clk);

    // HOLD_CYCLES=0: NOP then XY back to back from requester 0.
    do_reset();
    req_kind[0] = CMD_NOP;
    req_valid   = 4'b0001;
    #1 check("h0_nop_ready", ready_z, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    check("h0_nop_busy", busy_z, 0);
    check("h0_nop_xy", wxy_z, 0);
    check("h0_nop_dxy", wdxy_z, 0);
    check("h0_nop_en", en_z, 1);
    req_kind[0] = CMD_XY;
    req_x[0]    = 10'd7;
    req_y[0]    = 9'd3;
    #1 check("h0_xy_ready", ready_z, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("h0_xy_strobe", wxy_z, 1);
    check("h0_xy_x", wx_z, 7);
    check("h0_xy_y", wy_z, 3);
    check("h0_xy_en", en_z, 0);
    @(negedge clk);
    check("h0_after_xy", wxy_z, 0);
    check("h0_after_busy", busy_z, 0);
    check("h0_after_en", en_z, 1);

    // Reset during ISSUE, then priority restarts at requester 0.
    do_reset();
    req_kind[2] = CMD_XY;
    req_valid   = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("rmid_strobe_before", wxy, 1);
    rst = 1'b1;
    #1;
    check("rmid_strobe_killed", wxy, 0);
    check("rmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    req_kind[0] = CMD_XY;
    req_kind[3] = CMD_XY;
    req_valid   = 4'b1001;
    #1 check("rmid_prio_ready", ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("rmid_prio_gid", gid, 0);
    check("rmid_prio_xy", wxy, 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
